// File: rtl/ssqa_ctrl_fsm.sv
// ssqa_ctrl_fsm: annealing sequencer stepping RESET, per-spin MULT/drain/UPDATE
// and per-iteration LUPDATE/IRESET phases; exposes indices to the scheduler.
module ssqa_ctrl_fsm #(
   parameter int          NN      = 800,
   parameter logic [3:0]  IDLE    = 4'd0,
   parameter logic [3:0]  RESET   = 4'd1,
   parameter logic [3:0]  STMULT  = 4'd2,
   parameter logic [3:0]  MULT    = 4'd3,
   parameter logic [3:0]  LMULT   = 4'd4,
   parameter logic [3:0]  LLMULT  = 4'd5,
   parameter logic [3:0]  LLLMULT = 4'd6,
   parameter logic [3:0]  UPDATE  = 4'd7,
   parameter logic [3:0]  LUPDATE = 4'd8,
   parameter logic [3:0]  IRESET  = 4'd9,
   parameter logic [3:0]  FIN     = 4'd10
) (
   input  logic                   clk,
   input  logic                   rst_sys,
   input  logic                   start,
   input  logic                   abort,
   input  logic [$clog2(NN):0]    cfg_nspin,
   input  logic [15:0]            cfg_iter,
   output logic [3:0]             state,
   output logic [$clog2(NN)-1:0]  spin_idx,
   output logic [$clog2(NN)-1:0]  mult_idx,
   output logic [15:0]            iter_idx,
   output logic                   busy,
   output logic                   done
);

   localparam int NSW = $clog2(NN) + 1;
   localparam int IW  = $clog2(NN);
   localparam logic [NSW-1:0] NN_V = NSW'(NN);

   typedef enum logic [3:0] {
      ST_IDLE    = IDLE,
      ST_RESET   = RESET,
      ST_STMULT  = STMULT,
      ST_MULT    = MULT,
      ST_LMULT   = LMULT,
      ST_LLMULT  = LLMULT,
      ST_LLLMULT = LLLMULT,
      ST_UPDATE  = UPDATE,
      ST_LUPDATE = LUPDATE,
      ST_IRESET  = IRESET,
      ST_FIN     = FIN
   } state_t;

   state_t          state_q, state_d;
   logic [NSW-1:0]  ns_q, ns_d;
   logic [15:0]     ni_q, ni_d;
   logic [IW-1:0]   spin_d, mult_d;
   logic [15:0]     iter_d, iter_inc;
   logic [NSW-1:0]  ns_last;
   logic            mult_last, spin_last;

   assign ns_last   = ns_q - NSW'(1);
   assign mult_last = ({1'b0, mult_idx} == ns_last);
   assign spin_last = ({1'b0, spin_idx} == ns_last);
   assign iter_inc  = iter_idx + 16'd1;

   always_ff @(posedge clk or negedge rst_sys) begin
      if (!rst_sys) begin
         state_q  <= ST_IDLE;
         ns_q     <= '0;
         ni_q     <= '0;
         spin_idx <= '0;
         mult_idx <= '0;
         iter_idx <= '0;
      end else begin
         state_q  <= state_d;
         ns_q     <= ns_d;
         ni_q     <= ni_d;
         spin_idx <= spin_d;
         mult_idx <= mult_d;
         iter_idx <= iter_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ns_d    = ns_q;
      ni_d    = ni_q;
      spin_d  = spin_idx;
      mult_d  = mult_idx;
      iter_d  = iter_idx;
      // abort freezes the counters and only redirects the state
      if (abort && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && !abort) begin
                  state_d = ST_RESET;
                  spin_d  = '0;
                  mult_d  = '0;
                  iter_d  = '0;
                  ns_d    = (cfg_nspin == '0 || cfg_nspin > NN_V) ? NN_V : cfg_nspin;
                  ni_d    = (cfg_iter == '0) ? 16'd1 : cfg_iter;
               end
            end
            ST_RESET: begin
               if (mult_last) begin
                  state_d = ST_STMULT;
                  mult_d  = '0;
               end else begin
                  mult_d  = mult_idx + IW'(1);
               end
            end
            ST_STMULT:  state_d = ST_MULT;
            ST_MULT: begin
               if (mult_last) begin
                  state_d = ST_LMULT;
                  mult_d  = '0;
               end else begin
                  mult_d  = mult_idx + IW'(1);
               end
            end
            ST_LMULT:   state_d = ST_LLMULT;
            ST_LLMULT:  state_d = ST_LLLMULT;
            ST_LLLMULT: state_d = ST_UPDATE;
            ST_UPDATE: begin
               if (spin_last) begin
                  state_d = ST_LUPDATE;
               end else begin
                  state_d = ST_STMULT;
                  spin_d  = spin_idx + IW'(1);
               end
            end
            ST_LUPDATE: begin
               iter_d  = iter_inc;
               state_d = (iter_inc == ni_q) ? ST_FIN : ST_IRESET;
            end
            ST_IRESET: begin
               spin_d  = '0;
               state_d = ST_STMULT;
            end
            ST_FIN:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   assign state = state_q;
   assign busy  = (state_q != ST_IDLE);
   assign done  = (state_q == ST_FIN);

endmodule

// File: tb/tb_ssqa_ctrl_fsm.sv
// Directed, table-driven bench for ssqa_ctrl_fsm built with NN=4.
module tb_ssqa_ctrl_fsm;

   localparam logic [3:0] S_IDLE = 4'd0, S_RESET = 4'd1, S_STMULT = 4'd2, S_MULT = 4'd3,
                          S_LMULT = 4'd4, S_LLMULT = 4'd5, S_LLLMULT = 4'd6, S_UPDATE = 4'd7,
                          S_LUPDATE = 4'd8, S_IRESET = 4'd9, S_FIN = 4'd10;

   logic        clk = 1'b0;
   logic        rst_sys;
   logic        start;
   logic        abort;
   logic [2:0]  cfg_nspin;
   logic [15:0] cfg_iter;
   logic [3:0]  state;
   logic [1:0]  spin_idx;
   logic [1:0]  mult_idx;
   logic [15:0] iter_idx;
   logic        busy;
   logic        done;

   int unsigned total = 0;
   int unsigned bad   = 0;

   ssqa_ctrl_fsm #(.NN(4)) dut (
      .clk(clk), .rst_sys(rst_sys), .start(start), .abort(abort),
      .cfg_nspin(cfg_nspin), .cfg_iter(cfg_iter), .state(state),
      .spin_idx(spin_idx), .mult_idx(mult_idx), .iter_idx(iter_idx),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  nspin;
      logic [15:0] iter;
      int unsigned ns;
      int unsigned ni;
      int unsigned len;
   } vec_t;

   vec_t vecs[9];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Starts a run, scrambles config afterwards, and checks length and counter ranges.
   task automatic run_vec(input vec_t v, input int idx);
      int unsigned len = 0, ir = 0, mc = 0, maxm = 0, maxs = 0, dn = 0;
      logic [15:0] fin_iter;
      cfg_nspin = v.nspin;
      cfg_iter  = v.iter;
      start = 1'b1;
      step();
      start = 1'b0;
      cfg_nspin = 3'($urandom);
      cfg_iter  = 16'($urandom);
      chk($sformatf("v%0d first_state", idx), state, S_RESET);
      while (state != S_FIN && len < 2000) begin
         if (state == S_IRESET) ir++;
         if (state == S_MULT) mc++;
         if (done) dn++;
         if (mult_idx > maxm) maxm = mult_idx;
         if (spin_idx > maxs) maxs = spin_idx;
         step();
         len++;
      end
      chk($sformatf("v%0d run_len", idx), len, v.len);
      chk($sformatf("v%0d ireset_cycles", idx), ir, v.ni - 1);
      chk($sformatf("v%0d mult_cycles", idx), mc, v.ns * v.ns * v.ni);
      chk($sformatf("v%0d early_done", idx), dn, 0);
      chk($sformatf("v%0d max_mult", idx), maxm, v.ns - 1);
      chk($sformatf("v%0d max_spin", idx), maxs, v.ns - 1);
      chk($sformatf("v%0d done_at_fin", idx), done, 1);
      chk($sformatf("v%0d final_iter", idx), iter_idx, v.ni);
      chk($sformatf("v%0d final_spin", idx), spin_idx, v.ns - 1);
      fin_iter = iter_idx;
      step();
      chk($sformatf("v%0d back_idle", idx), state, S_IDLE);
      chk($sformatf("v%0d idle_flags", idx), {busy, done}, 0);
      chk($sformatf("v%0d iter_hold", idx), iter_idx, fin_iter);
   endtask

   logic [3:0] trace[18];

   initial begin
      int unsigned n;
      vecs[0] = '{3'd2, 16'd1, 2, 1, 17};
      vecs[1] = '{3'd3, 16'd3, 3, 3, 80};
      vecs[2] = '{3'd0, 16'd0, 4, 1, 41};
      vecs[3] = '{3'd5, 16'd2, 4, 2, 79};
      vecs[4] = '{3'd1, 16'd1, 1, 1, 8};
      vecs[5] = '{3'd1, 16'd2, 1, 2, 16};
      vecs[6] = '{3'd7, 16'd1, 4, 1, 41};
      vecs[7] = '{3'd2, 16'd3, 2, 3, 49};
      vecs[8] = '{3'd3, 16'd0, 3, 1, 28};

      trace[0] = S_RESET;
      trace[1] = S_RESET;
      for (int s = 0; s < 2; s++) begin
         trace[2 + 7*s] = S_STMULT;
         trace[3 + 7*s] = S_MULT;
         trace[4 + 7*s] = S_MULT;
         trace[5 + 7*s] = S_LMULT;
         trace[6 + 7*s] = S_LLMULT;
         trace[7 + 7*s] = S_LLLMULT;
         trace[8 + 7*s] = S_UPDATE;
      end
      trace[16] = S_LUPDATE;
      trace[17] = S_FIN;

      rst_sys = 1'b0; start = 1'b0; abort = 1'b0; cfg_nspin = '0; cfg_iter = '0;
      #12;
      chk("reset_state", state, S_IDLE);
      chk("reset_counters", {spin_idx, mult_idx, iter_idx}, 0);
      chk("reset_flags", {busy, done}, 0);
      rst_sys = 1'b1;
      step();
      step();
      chk("idle_after_release", state, S_IDLE);

      start = 1'b1; abort = 1'b1;
      step();
      chk("start_with_abort_ignored", state, S_IDLE);
      start = 1'b0; abort = 1'b0;

      // exact state trace for ns=2, ni=1
      cfg_nspin = 3'd2; cfg_iter = 16'd1;
      start = 1'b1;
      for (int i = 0; i < 18; i++) begin
         step();
         start = 1'b0;
         chk($sformatf("trace_%0d", i), state, trace[i]);
      end
      step();
      chk("trace_end_idle", state, S_IDLE);

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // abort in MULT with spin_idx==1, then a clean run
      cfg_nspin = 3'd3; cfg_iter = 16'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (!(state == S_MULT && spin_idx == 2'd1) && n < 200) begin
         step();
         n++;
      end
      chk("abort_reached_mult_spin1", (n < 200) ? 1 : 0, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_state", state, S_IDLE);
      chk("abort_flags", {busy, done}, 0);
      step();
      chk("abort_stays_idle", state, S_IDLE);
      run_vec(vecs[0], 20);

      // async reset during UPDATE, between edges
      cfg_nspin = 3'd2; cfg_iter = 16'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (state != S_UPDATE && n < 200) begin
         step();
         n++;
      end
      chk("rst_reached_update", state, S_UPDATE);
      #2 rst_sys = 1'b0;
      #1;
      chk("midrst_state", state, S_IDLE);
      chk("midrst_counters", {spin_idx, mult_idx, iter_idx}, 0);
      chk("midrst_flags", {busy, done}, 0);
      #1 rst_sys = 1'b1;
      step();
      step();
      chk("midrst_wait_idle", state, S_IDLE);

      // start pulsed repeatedly while busy: ns=3, ni=1 length 28
      cfg_nspin = 3'd3; cfg_iter = 16'd1;
      start = 1'b1;
      step();
      n = 0;
      while (state != S_FIN && n < 200) begin
         start = ~start;
         step();
         n++;
      end
      start = 1'b0;
      chk("spam_run_len", n, 28);
      step();
      chk("spam_idle", state, S_IDLE);

      // start held through FIN restarts on first IDLE cycle
      cfg_nspin = 3'd1; cfg_iter = 16'd1;
      start = 1'b1;
      step();
      n = 0;
      while (state != S_FIN && n < 200) begin
         step();
         n++;
      end
      chk("held_len", n, 8);
      step();
      chk("held_idle", state, S_IDLE);
      step();
      start = 1'b0;
      chk("held_restart", state, S_RESET);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("held_abort_idle", state, S_IDLE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
